// File: rtl/analog_pkg.sv
// Shared binary64 constants and operand-class type for the analog voltage driver
// and other real-valued blocks.
package analog_pkg;

   localparam logic [63:0] F64_QNAN    = 64'h7FF8_0000_0000_0000;
   localparam logic [63:0] F64_PINF    = 64'h7FF0_0000_0000_0000;
   localparam logic [10:0] F64_EXP_MAX = 11'h7FF;

   typedef enum logic [2:0] {
      ZERO,
      SUB,
      NORM,
      INF,
      NAN
   } fclass_t;

   // Sign-cleared magnitude with exponent and mantissa passed through untouched.
   function automatic logic [63:0] f64_abs(input logic [63:0] x);
      return {1'b0, x[62:0]};
   endfunction

endpackage

// File: rtl/analog_if.sv
// Update/readback bundle of the analog node: sampled operand in, held voltage and
// class flags out.
interface analog_if #(
   parameter int W = 64
);
   logic         in_valid;
   logic [W-1:0] value;
   logic [W-1:0] v_out;
   logic         v_valid;
   logic         v_upd;
   logic         is_zero;
   logic         is_inf;
   logic         is_nan;
   logic         is_sub;

   modport master (
      output in_valid, value,
      input  v_out, v_valid, v_upd, is_zero, is_inf, is_nan, is_sub
   );

   modport slave (
      input  in_valid, value,
      output v_out, v_valid, v_upd, is_zero, is_inf, is_nan, is_sub
   );
endinterface

// File: rtl/analog_f64_classify.sv
// Combinational binary64 operand classifier; the sign bit does not affect the class.
module f64_classify
   import analog_pkg::*;
(
   input  logic [63:0] value,
   output fclass_t     fclass
);
   logic [10:0] exp_f;
   logic [51:0] man_f;
   logic        unused_sign;

   assign exp_f       = value[62:52];
   assign man_f       = value[51:0];
   assign unused_sign = value[63];

   always_comb begin
      fclass = NORM;
      if (exp_f == 11'd0) begin
         fclass = (man_f == 52'd0) ? ZERO : SUB;
      end else if (exp_f == F64_EXP_MAX) begin
         fclass = (man_f == 52'd0) ? INF : NAN;
      end
   end
endmodule

// File: rtl/analog.sv
// Voltage-contribution driver: registers abs(value) as the held node voltage,
// canonicalising NaN and signed zero, and reports its operand class.
module analog
   import analog_pkg::*;
#(
   parameter int W = 64
) (
   input  logic     clk,
   input  logic     rst,
   analog_if.slave  bus
);
   fclass_t      in_class;
   logic [W-1:0] v_out_d,   v_out_q;
   logic         v_valid_d, v_valid_q;
   logic         v_upd_d,   v_upd_q;
   logic         is_zero_d, is_zero_q;
   logic         is_inf_d,  is_inf_q;
   logic         is_nan_d,  is_nan_q;
   logic         is_sub_d,  is_sub_q;

   f64_classify u_classify (
      .value  (bus.value),
      .fclass (in_class)
   );

   // Between updates every register recirculates, so the node stays driven.
   always_comb begin
      v_out_d   = v_out_q;
      v_valid_d = v_valid_q;
      v_upd_d   = 1'b0;
      is_zero_d = is_zero_q;
      is_inf_d  = is_inf_q;
      is_nan_d  = is_nan_q;
      is_sub_d  = is_sub_q;
      if (bus.in_valid) begin
         v_valid_d = 1'b1;
         v_upd_d   = 1'b1;
         is_zero_d = (in_class == ZERO);
         is_inf_d  = (in_class == INF);
         is_nan_d  = (in_class == NAN);
         is_sub_d  = (in_class == SUB);
         case (in_class)
            ZERO:    v_out_d = '0;
            INF:     v_out_d = F64_PINF;
            NAN:     v_out_d = F64_QNAN;
            default: v_out_d = f64_abs(bus.value);
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_out_q   <= '0;
         v_valid_q <= 1'b0;
         v_upd_q   <= 1'b0;
         is_zero_q <= 1'b1;
         is_inf_q  <= 1'b0;
         is_nan_q  <= 1'b0;
         is_sub_q  <= 1'b0;
      end else begin
         v_out_q   <= v_out_d;
         v_valid_q <= v_valid_d;
         v_upd_q   <= v_upd_d;
         is_zero_q <= is_zero_d;
         is_inf_q  <= is_inf_d;
         is_nan_q  <= is_nan_d;
         is_sub_q  <= is_sub_d;
      end
   end

   assign bus.v_out   = v_out_q;
   assign bus.v_valid = v_valid_q;
   assign bus.v_upd   = v_upd_q;
   assign bus.is_zero = is_zero_q;
   assign bus.is_inf  = is_inf_q;
   assign bus.is_nan  = is_nan_q;
   assign bus.is_sub  = is_sub_q;
endmodule

// File: tb/tb_analog.sv
// Directed bench for the analog voltage driver: hand-computed binary64 vectors
// checked one cycle after each sampling edge.
module tb_analog;
   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   analog_if #(.W(64)) bus ();

   analog #(.W(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive on the falling edge, then return just after the next rising edge.
   task automatic applyStimulus(input logic valid, input logic [63:0] v);
      @(negedge clk);
      bus.in_valid = valid;
      bus.value    = v;
      @(posedge clk);
      #1;
   endtask

   task automatic checkBit(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // flags order: {is_zero, is_inf, is_nan, is_sub}
   task automatic checkOutput(input string tag, input logic [63:0] exp_out,
                              input logic [3:0] exp_flags, input logic exp_upd,
                              input logic exp_valid);
      n_assert++;
      assert (bus.v_out === exp_out) else begin
         n_fail++;
         $error("[TB] FAIL %s v_out: observed %h expected %h", tag, bus.v_out, exp_out);
      end
      n_assert++;
      assert ({bus.is_zero, bus.is_inf, bus.is_nan, bus.is_sub} === exp_flags) else begin
         n_fail++;
         $error("[TB] FAIL %s flags(z,i,n,s): observed %b expected %b", tag,
                {bus.is_zero, bus.is_inf, bus.is_nan, bus.is_sub}, exp_flags);
      end
      checkBit({tag, " v_upd"},   bus.v_upd,   exp_upd);
      checkBit({tag, " v_valid"}, bus.v_valid, exp_valid);
   endtask

   initial begin
      logic [63:0] rv;
      n_assert     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      bus.value    = 64'hBFF0_0000_0000_0000;
      @(posedge clk);
      #1;
      checkOutput("reset", 64'h0, 4'b1000, 1'b0, 1'b0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst          = 1'b0;

      applyStimulus(1'b1, 64'h3FF0_0000_0000_0000);
      checkOutput("pos_one", 64'h3FF0_0000_0000_0000, 4'b0000, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 64'hDEAD_BEEF_0000_0000);
      checkOutput("hold_10", 64'h3FF0_0000_0000_0000, 4'b0000, 1'b0, 1'b1);

      applyStimulus(1'b1, 64'hBFF0_0000_0000_0000);
      checkOutput("neg_one", 64'h3FF0_0000_0000_0000, 4'b0000, 1'b1, 1'b1);
      applyStimulus(1'b1, 64'h8000_0000_0000_0000);
      checkOutput("neg_zero", 64'h0, 4'b1000, 1'b1, 1'b1);
      applyStimulus(1'b1, 64'hFFF0_0000_0000_0000);
      checkOutput("neg_inf", 64'h7FF0_0000_0000_0000, 4'b0100, 1'b1, 1'b1);
      applyStimulus(1'b1, 64'hFFF0_0000_0000_0001);
      checkOutput("neg_snan", 64'h7FF8_0000_0000_0000, 4'b0010, 1'b1, 1'b1);
      applyStimulus(1'b1, 64'h7FFD_EAD0_0000_1234);
      checkOutput("qnan_payload", 64'h7FF8_0000_0000_0000, 4'b0010, 1'b1, 1'b1);
      applyStimulus(1'b1, 64'h8000_0000_0000_0001);
      checkOutput("neg_sub", 64'h0000_0000_0000_0001, 4'b0001, 1'b1, 1'b1);
      applyStimulus(1'b1, 64'h7FEF_FFFF_FFFF_FFFF);
      checkOutput("max_norm", 64'h7FEF_FFFF_FFFF_FFFF, 4'b0000, 1'b1, 1'b1);

      applyStimulus(1'b1, 64'hC004_0000_0000_0000);
      checkOutput("b2b_2p5", 64'h4004_0000_0000_0000, 4'b0000, 1'b1, 1'b1);
      applyStimulus(1'b1, 64'h4008_0000_0000_0000);
      checkOutput("b2b_3p0", 64'h4008_0000_0000_0000, 4'b0000, 1'b1, 1'b1);
      applyStimulus(1'b1, 64'hC01C_0000_0000_0000);
      checkOutput("b2b_7p0", 64'h401C_0000_0000_0000, 4'b0000, 1'b1, 1'b1);
      applyStimulus(1'b0, 64'h0);
      checkOutput("b2b_idle", 64'h401C_0000_0000_0000, 4'b0000, 1'b0, 1'b1);

      // Normal-range random sweep: exponent kept away from 0 and 2047.
      for (int i = 0; i < 16; i++) begin
         rv = {$urandom, $urandom};
         if (rv[62:52] == 11'h7FF || rv[62:52] == 11'h000) rv[62:52] = 11'h3FF;
         applyStimulus(1'b1, rv);
         n_assert++;
         assert (bus.v_out === {1'b0, rv[62:0]}) else begin
            n_fail++;
            $error("[TB] FAIL sweep v_out: observed %h expected %h", bus.v_out, {1'b0, rv[62:0]});
         end
      end

      // Asynchronous reset mid-cycle, then a sample held under reset is discarded.
      applyStimulus(1'b1, 64'hFFF0_0000_0000_0000);
      checkOutput("pre_reset", 64'h7FF0_0000_0000_0000, 4'b0100, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset", 64'h0, 4'b1000, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      bus.value    = 64'hBFF0_0000_0000_0000;
      @(posedge clk);
      #1;
      checkOutput("rst_discard", 64'h0, 4'b1000, 1'b0, 1'b0);
      @(negedge clk);
      rst       = 1'b0;
      bus.value = 64'hC010_0000_0000_0000;
      @(posedge clk);
      #1;
      checkOutput("first_after_rst", 64'h4010_0000_0000_0000, 4'b0000, 1'b1, 1'b1);
      applyStimulus(1'b0, 64'h0);
      checkOutput("after_rst_idle", 64'h4010_0000_0000_0000, 4'b0000, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/analog.md
# analog

Voltage-contribution driver: converts a sampled IEEE-754 double-precision `value` into the node voltage `V(out) = abs(value)`. It holds that voltage as a continuously driven level until the next update. It sits between the behavioural real-valued domain and any consumer that reads the node voltage. It also reports the operand class of the held voltage.

## Interface
Parameters:
- `W`, 64, operand width. Only 64 (IEEE-754 binary64) is supported.

Ports:
- `clk`, input, 1, rising-edge clock.
- `rst`, input, 1, asynchronous active-high reset.
- `in_valid`, input, 1, update strobe; `value` is sampled when high.
- `value`, input, 64, binary64 operand.
- `v_out`, output, 64, binary64 node voltage `abs(value)`, held.
- `v_valid`, output, 1, high once any sample has been taken since reset.
- `v_upd`, output, 1, one-cycle pulse on every update of `v_out`.
- `is_zero`, output, 1, class flag of the held `v_out`.
- `is_inf`, output, 1, class flag of the held `v_out`.
- `is_nan`, output, 1, class flag of the held `v_out`.
- `is_sub`, output, 1, class flag of the held `v_out` (subnormal).

## Operation
- Absolute value: `v_out = {1'b0, value[62:0]}`. Exponent and mantissa pass through bit-exact, with no rounding.
- `-0.0` (`64'h8000_0000_0000_0000`) maps to `+0.0` (`64'h0`).
- NaN handling:
  - A NaN input is canonicalised to quiet NaN `64'h7FF8_0000_0000_0000`. This includes signalling NaNs and any payload.
  - `is_nan` is set.
- Infinity: `±Inf` maps to `64'h7FF0_0000_0000_0000` with `is_inf` set.
- Class flags are decoded from exponent `e = value[62:52]` and mantissa `m = value[51:0]`:
  - zero: `e == 0` and `m == 0`.
  - subnormal: `e == 0` and `m != 0`.
  - inf: `e == 2047` and `m == 0`.
  - nan: `e == 2047` and `m != 0`.
  - Exactly one flag, or none for a normal number, is high while `v_valid`.
- Hold semantics: with `in_valid` low, `v_out` and the flags keep their last value indefinitely. Like an analog contribution, the node stays driven.
- Back-to-back `in_valid` on consecutive cycles updates the output every cycle. The last sample wins.

## Timing
- Latency is 1 cycle: `value` sampled at edge N appears on `v_out`, flags and `v_upd` after edge N.
- `v_upd` is high for exactly the cycle following each sampling edge.
- `v_valid` rises after the first sampling edge and stays high until reset.
- Reset state, applied immediately on `rst` assertion and independent of `clk`:
  - `v_out = 64'h0`.
  - `is_zero = 1`.
  - `is_inf = is_nan = is_sub = 0`.
  - `v_upd = 0`.
  - `v_valid = 0`.
- Reset mid-stream: a sample presented in the same cycle `rst` is high is discarded. The first sample taken is at the first edge with `rst` low.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Shared package `analog_pkg`, containing:
  - `F64_QNAN = 64'h7FF8_0000_0000_0000`.
  - `F64_PINF = 64'h7FF0_0000_0000_0000`.
  - `F64_EXP_MAX = 11'h7FF`.
  - Enum `fclass_t` with values `ZERO`, `SUB`, `NORM`, `INF`, `NAN`.
- One natural sub-module, `f64_classify`. It is purely combinational: 64-bit input → `fclass_t`. It is reusable by other real-valued blocks.
- Top level: classify, then abs/canonicalise mux, then output registers.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `v_out == 0`, `is_zero == 1`, `v_valid == 0` immediately.
- Positive one: `value = 64'h3FF0_0000_0000_0000` (1.0) with `in_valid` → next cycle `v_out == 64'h3FF0_0000_0000_0000`, `v_upd == 1`, no class flags. Output still equal 10 cycles later with `in_valid` low.
- Negative one: `value = 64'hBFF0_0000_0000_0000` (-1.0) → `v_out == 64'h3FF0_0000_0000_0000`.
- Signed zero and infinity:
  - `-0.0` → `v_out == 0`, `is_zero == 1`.
  - `64'hFFF0_0000_0000_0000` → `v_out == 64'h7FF0_0000_0000_0000`, `is_inf == 1`.
- NaN and subnormal:
  - `64'hFFF0_0000_0000_0001` → `v_out == 64'h7FF8_0000_0000_0000`, `is_nan == 1`.
  - `64'h8000_0000_0000_0001` → `v_out == 64'h0000_0000_0000_0001`, `is_sub == 1`.
- Back-to-back: `-2.5`, `3.0`, `-7.0` on consecutive cycles → `v_out` steps 2.5, 3.0, 7.0 on consecutive cycles with `v_upd` high throughout. Random sweep: `v_out == {0, value[62:0]}` for every non-NaN input.
